// File: rtl/pcg_wait_ctl.sv
// PCG access wait controller.
// Stalls a CPU that touches the same PCG plane twice within one raster
// phase, releasing it on a raster phase change, on entry to blanking or
// when the CPU drops its request.
// Optional build macro PCG_WAIT_TIMEOUT_EN adds a stall timeout that
// forces a release after TOV cycles and raises a sticky O_TIMEOUT flag.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_BLANK | non-display period, bitmap held clear, no stalls
// S_OPEN  | display, first access to each plane per phase accepted
// S_WAIT  | CPU stalled on a repeat access until phase change/release
module pcg_wait_ctl #(
  parameter int NPLANE   = 3,
  parameter int PSEL_LSB = 8,
  parameter int TOW      = 8,
  parameter int TOV      = 200
) (
  input  logic              I_CCLK,
  input  logic              I_RESET_n,
  input  logic              I_CG_CS,
  input  logic [15:0]       I_A,
  input  logic              I_VDISP,
  input  logic              I_QD,
  input  logic              I_RA0,
  output logic              O_CG_WAIT_n,
  output logic [NPLANE-1:0] O_PLANE_DONE,
  output logic              O_TIMEOUT
);

  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_OPEN  = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [TOW-1:0] TO_LAST = TOW'(TOV - 1);

  state_t            state;
  logic [NPLANE-1:0] done;
  logic              ra0_dly;
  logic              ra0_prev;
  logic              phase_chg;
  logic [1:0]        psel;
  logic [NPLANE-1:0] sel;
  logic              valid;
  logic              req_ok;
  logic              done_hit;
  logic              enter_wait;
  logic              to_hit;
  logic              to_flag;
  logic              unused_bits;

  assign psel      = I_A[PSEL_LSB+1:PSEL_LSB];
  assign phase_chg = ra0_dly ^ ra0_prev;

  // Address bits outside the plane-select field are not decoded here.
  assign unused_bits = ^{I_A, TO_LAST};

  // One-hot plane decode; selects beyond NPLANE leave sel empty (invalid).
  always_comb begin
    sel = '0;
    for (int i = 0; i < NPLANE; i++) begin
      if (psel == 2'(i)) sel[i] = 1'b1;
    end
  end

  assign valid      = |sel;
  assign req_ok     = I_CG_CS & valid;
  assign done_hit   = |(done & sel);
  assign enter_wait = (state == S_OPEN) & ~I_VDISP & ~phase_chg & req_ok & done_hit;

  // Raster phase tracking: RA0 sampled on the character clock, then delayed once.
  always_ff @(posedge I_CCLK) begin
    if (!I_RESET_n) begin
      ra0_dly  <= 1'b1;
      ra0_prev <= 1'b1;
    end else begin
      if (I_QD) ra0_dly <= I_RA0;
      ra0_prev <= ra0_dly;
    end
  end

`ifdef PCG_WAIT_TIMEOUT_EN
  logic [TOW-1:0] to_cnt;

  // Timeout fires on the last allowed stall cycle only if nothing else releases.
  assign to_hit = (state == S_WAIT) & (to_cnt == TO_LAST) & ~phase_chg &
                  I_CG_CS & ~I_VDISP;

  // Stall length counter and sticky timeout flag.
  always_ff @(posedge I_CCLK) begin
    if (!I_RESET_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (enter_wait)            to_cnt <= '0;
      else if (state == S_WAIT)  to_cnt <= to_cnt + 1'b1;
      if (to_hit)                to_flag <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign to_flag = 1'b0;
`endif

  // Plane bitmap and stall state machine.
  always_ff @(posedge I_CCLK) begin
    if (!I_RESET_n) begin
      state <= S_BLANK;
      done  <= '0;
    end else if (I_VDISP) begin
      state <= S_BLANK;
      done  <= '0;
    end else begin
      case (state)
        S_BLANK: state <= S_OPEN;
        S_OPEN: begin
          if (phase_chg) begin
            done <= req_ok ? sel : '0;
          end else if (req_ok) begin
            if (!done_hit) done  <= done | sel;
            else           state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (phase_chg) begin
            state <= S_OPEN;
            done  <= req_ok ? sel : '0;
          end else if (!I_CG_CS || to_hit) begin
            state <= S_OPEN;
          end
        end
        default: begin
          state <= S_BLANK;
          done  <= '0;
        end
      endcase
    end
  end

  // Wait is combinational so the repeat access is stalled in its own cycle.
  assign O_CG_WAIT_n = ~(I_RESET_n & ~I_VDISP & I_CG_CS & ~phase_chg &
                        (((state == S_OPEN) & done_hit) |
                         ((state == S_WAIT) & ~to_hit)));

  assign O_PLANE_DONE = done;
  assign O_TIMEOUT    = to_flag;

endmodule

// File: tb/tb_pcg_wait_ctl.sv
// Directed-vector bench for pcg_wait_ctl with a queue-based scoreboard.
// Timeout expectations follow PCG_WAIT_TIMEOUT_EN when it is defined.
module tb_pcg_wait_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic [15:0] addr;
  logic        vdisp;
  logic        qd;
  logic        ra0;
  logic        wait_n;
  logic [2:0]  plane_done;
  logic        timeout;

  typedef struct {
    string      name;
    logic       wait_n;
    logic [2:0] done;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

`ifdef PCG_WAIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  pcg_wait_ctl #(.NPLANE(3), .PSEL_LSB(8), .TOW(8), .TOV(4)) dut (
    .I_CCLK       (clk),
    .I_RESET_n    (rst_n),
    .I_CG_CS      (cs),
    .I_A          (addr),
    .I_VDISP      (vdisp),
    .I_QD         (qd),
    .I_RA0        (ra0),
    .O_CG_WAIT_n  (wait_n),
    .O_PLANE_DONE (plane_done),
    .O_TIMEOUT    (timeout)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected at the following falling edge.
  task automatic vec(input string name, input logic r, input logic c,
                     input logic [15:0] a, input logic vd, input logic q,
                     input logic ra, input logic ew, input logic [2:0] ed,
                     input logic eto);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; cs = c; addr = a; vdisp = vd; qd = q; ra0 = ra;
    e.name = name; e.wait_n = ew; e.done = ed; e.to = eto;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (wait_n !== e.wait_n || plane_done !== e.done || timeout !== e.to) begin
        n_fail++;
        $display("FAIL %s: got wait_n=%b done=%b timeout=%b, expected wait_n=%b done=%b timeout=%b",
                 e.name, wait_n, plane_done, timeout, e.wait_n, e.done, e.to);
      end
    end
  end

  initial begin
    rst_n = 1'b0; cs = 1'b0; addr = 16'h0; vdisp = 1'b1; qd = 1'b0; ra0 = 1'b1;

    //   name           rst cs  addr     vd qd ra  wait done    to
    vec("reset",        0, 0, 16'h0000, 1, 0, 1, 1, 3'b000, 0);
    vec("reset_rel",    1, 0, 16'h0000, 0, 0, 1, 1, 3'b000, 0);
    vec("first_p1",     1, 1, 16'h0100, 0, 0, 1, 1, 3'b000, 0);
    vec("done_p1",      1, 0, 16'h0100, 0, 0, 1, 1, 3'b010, 0);
    vec("repeat_p1",    1, 1, 16'h0100, 0, 0, 1, 0, 3'b010, 0);
    vec("wait_hold",    1, 1, 16'h0100, 0, 1, 0, 0, 3'b010, 0);
    vec("phase_rel",    1, 1, 16'h0100, 0, 0, 0, 1, 3'b010, 0);
    vec("after_rel",    1, 0, 16'h0100, 0, 0, 0, 1, 3'b010, 0);
    vec("rewait_p1",    1, 1, 16'h0100, 0, 0, 0, 0, 3'b010, 0);
    vec("vdisp_rel",    1, 1, 16'h0100, 1, 0, 0, 1, 3'b010, 0);
    vec("blank_clr",    1, 1, 16'h0100, 0, 0, 0, 1, 3'b000, 0);
    vec("open_idle",    1, 0, 16'h0100, 0, 0, 0, 1, 3'b000, 0);
    for (int i = 0; i < 5; i++)
      vec("invalid_p3", 1, 1, 16'h0300, 0, 0, 0, 1, 3'b000, 0);
    vec("invalid_done", 1, 0, 16'h0300, 0, 0, 0, 1, 3'b000, 0);
    vec("first_p0",     1, 1, 16'h0000, 0, 0, 0, 1, 3'b000, 0);
    vec("repeat_p0",    1, 1, 16'h0000, 0, 0, 0, 0, 3'b001, 0);
    vec("cs_drop_rel",  1, 0, 16'h0000, 0, 0, 0, 1, 3'b001, 0);
    vec("first_p2",     1, 1, 16'h0200, 0, 0, 0, 1, 3'b001, 0);
    vec("first_p1b",    1, 1, 16'h0100, 0, 0, 0, 1, 3'b101, 0);
    vec("all_done",     1, 0, 16'h0000, 0, 0, 0, 1, 3'b111, 0);
    vec("ra0_toggle",   1, 0, 16'h0000, 0, 1, 1, 1, 3'b111, 0);
    vec("p0_at_phase",  1, 1, 16'h0000, 0, 0, 1, 1, 3'b111, 0);
    vec("phase_bitmap", 1, 0, 16'h0000, 0, 0, 1, 1, 3'b001, 0);
    vec("rewait_p0",    1, 1, 16'h0000, 0, 0, 1, 0, 3'b001, 0);
    vec("rst_mid_wait", 0, 1, 16'h0000, 0, 0, 1, 1, 3'b001, 0);
    vec("post_rst",     1, 0, 16'h0000, 0, 0, 1, 1, 3'b000, 0);
    vec("to_first",     1, 1, 16'h0100, 0, 0, 1, 1, 3'b000, 0);
    vec("to_enter",     1, 1, 16'h0100, 0, 0, 1, 0, 3'b010, 0);
    vec("to_wait0",     1, 1, 16'h0100, 0, 0, 1, 0, 3'b010, 0);
    vec("to_wait1",     1, 1, 16'h0100, 0, 0, 1, 0, 3'b010, 0);
    vec("to_wait2",     1, 1, 16'h0100, 0, 0, 1, 0, 3'b010, 0);
    vec("to_expire",    1, 1, 16'h0100, 0, 0, 1, TO_EN ? 1'b1 : 1'b0, 3'b010, 0);
    vec("to_sticky0",   1, 0, 16'h0100, 0, 0, 1, 1, 3'b010, TO_EN);
    vec("to_sticky1",   1, 0, 16'h0100, 0, 0, 1, 1, 3'b010, TO_EN);
    vec("to_sticky2",   1, 0, 16'h0100, 0, 0, 1, 1, 3'b010, TO_EN);
    vec("to_rst",       0, 0, 16'h0100, 0, 0, 1, 1, 3'b010, TO_EN);
    vec("to_cleared",   1, 0, 16'h0100, 0, 0, 1, 1, 3'b000, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
